// File: rtl/tl_rx_ur_report.sv
// Unsupported-request reporting: UR completion queue, ERR_NONFATAL message
// request, URD status and first-error header log. Optional TL_RX_UR_ERR_CNT_EN adds ur_count.
module tl_rx_ur_report #(
  parameter int DEPTH     = 4,
  parameter int HDR_WIDTH = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tlp_valid,
  input  logic                 ur_error,
  input  logic                 non_posted,
  input  logic [HDR_WIDTH-1:0] tlp_hdr,
  input  logic [15:0]          req_id,
  input  logic [9:0]           tag,
  input  logic [5:0]           tc_attr,
  input  logic [6:0]           lower_addr,
  input  logic                 ur_report_en,
  input  logic                 nonfatal_en,
  input  logic                 status_clr,
  output logic                 cpl_valid,
  input  logic                 cpl_ready,
  output logic [38:0]          cpl_desc,
  output logic                 msg_valid,
  input  logic                 msg_ready,
  output logic [7:0]           msg_code,
  output logic                 urd_status,
  output logic [HDR_WIDTH-1:0] hdr_log,
  output logic                 hdr_log_valid,
  output logic                 cpl_overflow
`ifdef TL_RX_UR_ERR_CNT_EN
  ,
  output logic [15:0]          ur_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic [1:0] {IDLE, SEND, HOLD} msg_state_e;

  logic ur_event;
  logic msg_event;

  assign ur_event  = tlp_valid && ur_error;
  assign msg_event = ur_event && ur_report_en && nonfatal_en;

  // Pending-completion FIFO: extra pointer MSB distinguishes full from empty.
  logic [38:0] mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        fifo_full;
  logic        push_req;
  logic        push;
  logic        pop;

  assign fifo_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_req  = ur_event && non_posted;
  assign pop       = cpl_valid && cpl_ready;
  assign push      = push_req && (!fifo_full || pop);

  // NOTE: storage carries no reset; only the pointers define what is valid,
  // which keeps the array a plain RAM without a reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {req_id, tag, tc_attr, lower_addr};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cpl_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push_req && !push) cpl_overflow <= 1'b1;
    end
  end

  assign cpl_valid = (wr_ptr != rd_ptr);
  assign cpl_desc  = cpl_valid ? mem[rd_ptr[AW-1:0]] : '0;

  // A UR event in the same cycle as status_clr wins over the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      urd_status    <= 1'b0;
      hdr_log       <= '0;
      hdr_log_valid <= 1'b0;
    end else begin
      if (ur_event)        urd_status <= 1'b1;
      else if (status_clr) urd_status <= 1'b0;

      if (ur_event && (!hdr_log_valid || status_clr)) begin
        hdr_log       <= tlp_hdr;
        hdr_log_valid <= 1'b1;
      end else if (status_clr) begin
        hdr_log_valid <= 1'b0;
      end
    end
  end

  msg_state_e state_q;
  msg_state_e state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: next state takes its default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (msg_event) state_d = SEND;
      SEND: begin
        if (msg_ready)      state_d = msg_event ? SEND : IDLE;
        else if (msg_event) state_d = HOLD;
      end
      HOLD: if (msg_ready) state_d = SEND;
      default: state_d = IDLE;
    endcase
  end

  assign msg_valid = (state_q != IDLE);
  assign msg_code  = msg_valid ? 8'h31 : 8'h00;

`ifdef TL_RX_UR_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ur_count <= '0;
    end else if (status_clr) begin
      ur_count <= ur_event ? 16'd1 : 16'd0;
    end else if (ur_event && (ur_count != 16'hFFFF)) begin
      ur_count <= ur_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tl_rx_ur_report.sv
// Self-checking bench for tl_rx_ur_report: directed scenarios with literal
// expectations plus randomized traffic against a queue/counter reference model.
module tb_tl_rx_ur_report;

  localparam int DEPTH = 4;
  localparam int HW    = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tlp_valid = 1'b0;
  logic          ur_error = 1'b0;
  logic          non_posted = 1'b0;
  logic [HW-1:0] tlp_hdr = '0;
  logic [15:0]   req_id = '0;
  logic [9:0]    tag = '0;
  logic [5:0]    tc_attr = '0;
  logic [6:0]    lower_addr = '0;
  logic          ur_report_en = 1'b0;
  logic          nonfatal_en = 1'b0;
  logic          status_clr = 1'b0;
  logic          cpl_valid;
  logic          cpl_ready = 1'b0;
  logic [38:0]   cpl_desc;
  logic          msg_valid;
  logic          msg_ready = 1'b0;
  logic [7:0]    msg_code;
  logic          urd_status;
  logic [HW-1:0] hdr_log;
  logic          hdr_log_valid;
  logic          cpl_overflow;
`ifdef TL_RX_UR_ERR_CNT_EN
  logic [15:0]   ur_count;
`endif

  tl_rx_ur_report #(.DEPTH(DEPTH), .HDR_WIDTH(HW)) dut (
    .clk(clk), .rst(rst), .tlp_valid(tlp_valid), .ur_error(ur_error),
    .non_posted(non_posted), .tlp_hdr(tlp_hdr), .req_id(req_id), .tag(tag),
    .tc_attr(tc_attr), .lower_addr(lower_addr), .ur_report_en(ur_report_en),
    .nonfatal_en(nonfatal_en), .status_clr(status_clr), .cpl_valid(cpl_valid),
    .cpl_ready(cpl_ready), .cpl_desc(cpl_desc), .msg_valid(msg_valid),
    .msg_ready(msg_ready), .msg_code(msg_code), .urd_status(urd_status),
    .hdr_log(hdr_log), .hdr_log_valid(hdr_log_valid), .cpl_overflow(cpl_overflow)
`ifdef TL_RX_UR_ERR_CNT_EN
    , .ur_count(ur_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int hs_cnt = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: descriptor queue, outstanding-message count, plain flags.
  logic [38:0]   mq[$];
  logic          m_ovf = 1'b0;
  logic          m_urd = 1'b0;
  logic          m_hv  = 1'b0;
  logic [HW-1:0] m_log = '0;
  int            m_pend = 0;
  logic [15:0]   m_cnt = '0;

  // Compare, then advance the model with the inputs the DUT sees next edge.
  initial forever begin
    @(negedge clk);
    check("cpl_valid", 128'(cpl_valid), 128'(mq.size() != 0));
    if (mq.size() != 0) check("cpl_desc", 128'(cpl_desc), 128'(mq[0]));
    check("cpl_overflow", 128'(cpl_overflow), 128'(m_ovf));
    check("urd_status", 128'(urd_status), 128'(m_urd));
    check("hdr_log_valid", 128'(hdr_log_valid), 128'(m_hv));
    if (m_hv) check("hdr_log", hdr_log, m_log);
    check("msg_valid", 128'(msg_valid), 128'(m_pend != 0));
    if (m_pend != 0) check("msg_code", 128'(msg_code), 128'(8'h31));
`ifdef TL_RX_UR_ERR_CNT_EN
    check("ur_count", 128'(ur_count), 128'(m_cnt));
`endif
    if (msg_valid && msg_ready) hs_cnt++;

    if (rst) begin
      mq.delete();
      m_ovf = 1'b0; m_urd = 1'b0; m_hv = 1'b0; m_log = '0; m_pend = 0; m_cnt = '0;
    end else begin
      automatic logic ev   = tlp_valid && ur_error;
      automatic logic qual = ev && ur_report_en && nonfatal_en;
      automatic int   p    = m_pend;
      if (mq.size() != 0 && cpl_ready) void'(mq.pop_front());
      if (ev && non_posted) begin
        if (mq.size() < DEPTH) mq.push_back({req_id, tag, tc_attr, lower_addr});
        else m_ovf = 1'b1;
      end
      if (ev) m_urd = 1'b1;
      else if (status_clr) m_urd = 1'b0;
      if (ev && (!m_hv || status_clr)) begin
        m_log = tlp_hdr; m_hv = 1'b1;
      end else if (status_clr) begin
        m_hv = 1'b0;
      end
      m_pend = p - ((p > 0 && msg_ready) ? 1 : 0) + ((qual && p < 2) ? 1 : 0);
      if (status_clr) m_cnt = ev ? 16'd1 : 16'd0;
      else if (ev && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_in();
    tlp_valid = 1'b0; ur_error = 1'b0; status_clr = 1'b0; rst = 1'b0;
  endtask

  task automatic ur(input logic np, input logic [HW-1:0] h, input logic [15:0] rid,
                    input logic [9:0] tg, input logic [5:0] tca, input logic [6:0] la);
    tlp_valid = 1'b1; ur_error = 1'b1; non_posted = np; tlp_hdr = h;
    req_id = rid; tag = tg; tc_attr = tca; lower_addr = la;
  endtask

  function automatic logic [HW-1:0] rnd_hdr();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    automatic logic [HW-1:0] h1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    automatic logic [HW-1:0] h4 = 128'h4444_0000_4444_0000_4444_0000_4444_0004;
    automatic logic [HW-1:0] h5 = 128'h5555_5555_5555_5555_5555_5555_5555_5555;
    automatic logic [HW-1:0] h6 = 128'h6666_abcd_6666_abcd_6666_abcd_6666_abcd;
    automatic int hs0;
    automatic bit drained;

    // Reset state
    repeat (2) @(posedge clk);
    #2 idle_in();
    @(negedge clk);
    check("rst_cpl_valid", 128'(cpl_valid), 128'(0));
    check("rst_msg_valid", 128'(msg_valid), 128'(0));
    check("rst_hdr_log", hdr_log, 128'(0));
`ifdef TL_RX_UR_ERR_CNT_EN
    check("rst_ur_count", 128'(ur_count), 128'(0));
`endif

    // Single non-posted UR
    next_cyc();
    cpl_ready = 1'b1;
    ur(1'b1, h1, 16'h0100, 10'h05, 6'h00, 7'h10);
    next_cyc();
    idle_in();
    @(negedge clk);
    check("single_cpl_valid", 128'(cpl_valid), 128'(1));
    check("single_cpl_desc", 128'(cpl_desc), 128'({16'h0100, 10'h05, 6'h00, 7'h10}));
    check("single_urd", 128'(urd_status), 128'(1));
    check("single_hdr_log", hdr_log, h1);
    check("single_hdr_valid", 128'(hdr_log_valid), 128'(1));
    @(negedge clk);
    check("single_cpl_gone", 128'(cpl_valid), 128'(0));

    // Five back-to-back non-posted URs into a 4-deep FIFO
    next_cyc();
    cpl_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ur(1'b1, rnd_hdr(), 16'h1234, 10'(i + 1), 6'h2a, 7'h33);
      next_cyc();
    end
    idle_in();
    @(negedge clk);
    check("ovf_flag", 128'(cpl_overflow), 128'(1));
    next_cyc();
    cpl_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      automatic logic [38:0] e = {16'h1234, 10'(k + 1), 6'h2a, 7'h33};
      @(negedge clk);
      check("drain_valid", 128'(cpl_valid), 128'(1));
      check("drain_desc", 128'(cpl_desc), 128'(e));
    end
    @(negedge clk);
    check("drain_empty", 128'(cpl_valid), 128'(0));

    // Two posted URs with messages stalled, coalesced into one extra message
    next_cyc();
    ur_report_en = 1'b1; nonfatal_en = 1'b1; msg_ready = 1'b0;
    hs0 = hs_cnt;
    ur(1'b0, rnd_hdr(), 16'h0200, 10'h0a, 6'h11, 7'h01);
    next_cyc();
    ur(1'b0, rnd_hdr(), 16'h0201, 10'h0b, 6'h12, 7'h02);
    next_cyc();
    idle_in();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("msg_hold_valid", 128'(msg_valid), 128'(1));
      check("msg_hold_code", 128'(msg_code), 128'(8'h31));
    end
    next_cyc();
    msg_ready = 1'b1;
    drained = 1'b0;
    for (int i = 0; i < 10 && !drained; i++) begin
      @(negedge clk);
      if (!msg_valid) drained = 1'b1;
    end
    check("msg_drained", 128'(drained), 128'(1));
    check("msg_handshakes", 128'(hs_cnt - hs0), 128'(2));

    // Posted UR with reporting disabled, after clearing the log
    next_cyc();
    ur_report_en = 1'b0;
    status_clr = 1'b1;
    next_cyc();
    status_clr = 1'b0;
    ur(1'b0, h4, 16'h0300, 10'h0c, 6'h00, 7'h00);
    next_cyc();
    idle_in();
    @(negedge clk);
    check("noreport_msg", 128'(msg_valid), 128'(0));
    check("noreport_urd", 128'(urd_status), 128'(1));
    check("noreport_hdr", hdr_log, h4);
    check("noreport_cpl", 128'(cpl_valid), 128'(0));
    @(negedge clk);
    check("noreport_msg2", 128'(msg_valid), 128'(0));

    // Later UR keeps the log; clear coincident with a UR recaptures
    next_cyc();
    ur(1'b0, h5, 16'h0400, 10'h0d, 6'h00, 7'h00);
    next_cyc();
    idle_in();
    @(negedge clk);
    check("keep_hdr", hdr_log, h4);
    next_cyc();
    ur(1'b0, h6, 16'h0500, 10'h0e, 6'h00, 7'h00);
    status_clr = 1'b1;
    next_cyc();
    idle_in();
    @(negedge clk);
    check("clr_ur_urd", 128'(urd_status), 128'(1));
    check("clr_ur_hdr", hdr_log, h6);
    check("clr_ur_hdr_valid", 128'(hdr_log_valid), 128'(1));

    // Reset while both handshakes are pending
    next_cyc();
    ur_report_en = 1'b1; nonfatal_en = 1'b1; cpl_ready = 1'b0; msg_ready = 1'b0;
    ur(1'b1, rnd_hdr(), 16'h0600, 10'h0f, 6'h07, 7'h05);
    next_cyc();
    idle_in();
    @(negedge clk);
    check("pre_rst_cpl", 128'(cpl_valid), 128'(1));
    check("pre_rst_msg", 128'(msg_valid), 128'(1));
    next_cyc();
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cpl", 128'(cpl_valid), 128'(0));
    check("post_rst_desc", 128'(cpl_desc), 128'(0));
    check("post_rst_msg", 128'(msg_valid), 128'(0));
    check("post_rst_code", 128'(msg_code), 128'(0));
    check("post_rst_urd", 128'(urd_status), 128'(0));
    check("post_rst_hv", 128'(hdr_log_valid), 128'(0));
    check("post_rst_hdr", hdr_log, 128'(0));
    check("post_rst_ovf", 128'(cpl_overflow), 128'(0));
`ifdef TL_RX_UR_ERR_CNT_EN
    check("post_rst_count", 128'(ur_count), 128'(0));
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      next_cyc();
      rst          = ($urandom_range(0, 199) == 0);
      tlp_valid    = $urandom_range(0, 1);
      ur_error     = ($urandom_range(0, 9) < 6);
      non_posted   = $urandom_range(0, 1);
      tlp_hdr      = rnd_hdr();
      req_id       = 16'($urandom);
      tag          = 10'($urandom);
      tc_attr      = 6'($urandom);
      lower_addr   = 7'($urandom);
      ur_report_en = ($urandom_range(0, 9) < 8);
      nonfatal_en  = ($urandom_range(0, 9) < 8);
      status_clr   = ($urandom_range(0, 9) == 0);
      cpl_ready    = $urandom_range(0, 1);
      msg_ready    = ($urandom_range(0, 9) < 4);
    end
    next_cyc();
    idle_in();

`ifdef TL_RX_UR_ERR_CNT_EN
    // Counter saturation
    status_clr = 1'b1;
    next_cyc();
    status_clr = 1'b0;
    non_posted = 1'b0; cpl_ready = 1'b1; msg_ready = 1'b1;
    tlp_valid = 1'b1; ur_error = 1'b1;
    for (int i = 0; i < 65537; i++) next_cyc();
    idle_in();
    @(negedge clk);
    check("count_saturated", 128'(ur_count), 128'(16'hFFFF));
    next_cyc();
`endif

    repeat (3) next_cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
